// File: rtl/fxp8s_pkg.sv
// Shared constants and state type for the fxp8s PE sequencer.
// Defining FXP8S_SEQ_CLR_EN adds the CLR state used by the CLEAR command.
package fxp8s_pkg;

    localparam int FXP8S_WIDTH     = 8;
    localparam int FXP8S_DRAIN_CYC = 3;

    localparam logic [1:0] OP_ROW   = 2'd0;
    localparam logic [1:0] OP_COL   = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RSP  = 2'd2
`ifdef FXP8S_SEQ_CLR_EN
        , ST_CLR = 2'd3
`endif
    } seq_state_t;

endpackage

// File: rtl/fxp8s_sel_dec.sv
// NPE-wide one-hot select decoder with an all-ones override.
// Indices at or above NPE decode to zero, so an out-of-range select enables nothing.
module fxp8s_sel_dec #(
    parameter int NPE   = 4,
    parameter int SEL_W = 2
) (
    input  logic             en,
    input  logic             sel_all,
    input  logic [SEL_W-1:0] sel,
    output logic [NPE-1:0]   onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NPE; gi++) begin : g_bit
            assign onehot[gi] = en & (sel_all | (sel == SEL_W'(gi)));
        end
    endgenerate

endmodule

// File: rtl/fxp8s_pe_seq.sv
// Command sequencer for a column of fxp8s_pe elements sharing one input and one output bus.
// Build option FXP8S_SEQ_CLR_EN enables the CLEAR command (PE reset pulse); otherwise op 3 is a no-op.
module fxp8s_pe_seq
    import fxp8s_pkg::*;
#(
    parameter  int NPE       = 4,
    parameter  int DRAIN_CYC = FXP8S_DRAIN_CYC,
    localparam int SEL_W     = (NPE > 1) ? $clog2(NPE) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [SEL_W-1:0]       cmd_sel,
    input  logic                   cmd_all,
    input  logic [FXP8S_WIDTH-1:0] cmd_data,
    output logic                   pe_in_row,
    output logic [NPE-1:0]         pe_en_in,
    output logic [FXP8S_WIDTH-1:0] pe_in_data,
    output logic [NPE-1:0]         pe_en_out,
    input  logic [FXP8S_WIDTH-1:0] pe_out_data,
    output logic                   pe_rstn,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [FXP8S_WIDTH-1:0] rsp_data,
    output logic [SEL_W-1:0]       rsp_sel,
    output logic                   busy
);

    localparam int                 DRAIN_W    = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC);
    localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(NPE - 1);

    seq_state_t             state_reg, state_next;
    logic [DRAIN_W-1:0]     drain_reg, drain_next;
    logic [SEL_W-1:0]       idx_reg, idx_next;
    logic                   rd_all_reg, rd_all_next;
    logic [NPE-1:0]         en_in_reg, en_in_next;
    logic                   in_row_reg, in_row_next;
    logic [FXP8S_WIDTH-1:0] in_data_reg, in_data_next;
    logic                   rstn_reg, rstn_next;
    logic [FXP8S_WIDTH-1:0] rsp_data_reg, rsp_data_next;

    logic           draining;
    logic           accept;
    logic           is_wr;
    logic [NPE-1:0] en_in_dec;

    // Reads and clears must wait for in-flight products to settle in the accumulators.
    assign draining  = (drain_reg != '0);
    assign cmd_ready = (state_reg == ST_IDLE) && !rst &&
                       !(draining && (cmd_op == OP_READ || cmd_op == OP_CLEAR));
    assign accept    = cmd_valid && cmd_ready;
    assign is_wr     = accept && (cmd_op == OP_ROW || cmd_op == OP_COL);

    fxp8s_sel_dec #(.NPE(NPE), .SEL_W(SEL_W)) u_dec_in (
        .en      (is_wr),
        .sel_all (cmd_all),
        .sel     (cmd_sel),
        .onehot  (en_in_dec)
    );

    fxp8s_sel_dec #(.NPE(NPE), .SEL_W(SEL_W)) u_dec_out (
        .en      (state_reg == ST_RD),
        .sel_all (1'b0),
        .sel     (idx_reg),
        .onehot  (pe_en_out)
    );

    always_comb begin
        state_next    = state_reg;
        drain_next    = draining ? drain_reg - DRAIN_W'(1) : drain_reg;
        idx_next      = idx_reg;
        rd_all_next   = rd_all_reg;
        en_in_next    = en_in_dec;
        in_row_next   = is_wr && (cmd_op == OP_ROW);
        in_data_next  = is_wr ? cmd_data : '0;
        rstn_next     = 1'b1;
        rsp_data_next = rsp_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_COL: drain_next = DRAIN_LOAD;
                        OP_READ: begin
                            state_next  = ST_RD;
                            idx_next    = cmd_all ? '0 : cmd_sel;
                            rd_all_next = cmd_all;
                        end
`ifdef FXP8S_SEQ_CLR_EN
                        OP_CLEAR: begin
                            state_next = ST_CLR;
                            rstn_next  = 1'b0;
                            drain_next = '0;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_RD: begin
                // Nothing drives the bus for an out-of-range index, so report zero instead.
                rsp_data_next = (|pe_en_out) ? pe_out_data : '0;
                state_next    = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    if (rd_all_reg && idx_reg != LAST_IDX) begin
                        idx_next   = idx_reg + SEL_W'(1);
                        state_next = ST_RD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
`ifdef FXP8S_SEQ_CLR_EN
            ST_CLR: state_next = ST_IDLE;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            drain_reg    <= '0;
            idx_reg      <= '0;
            rd_all_reg   <= 1'b0;
            en_in_reg    <= '0;
            in_row_reg   <= 1'b0;
            in_data_reg  <= '0;
            rstn_reg     <= 1'b0;
            rsp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            drain_reg    <= drain_next;
            idx_reg      <= idx_next;
            rd_all_reg   <= rd_all_next;
            en_in_reg    <= en_in_next;
            in_row_reg   <= in_row_next;
            in_data_reg  <= in_data_next;
            rstn_reg     <= rstn_next;
            rsp_data_reg <= rsp_data_next;
        end
    end

    assign pe_en_in   = en_in_reg;
    assign pe_in_row  = in_row_reg;
    assign pe_in_data = in_data_reg;
    assign pe_rstn    = rstn_reg;
    assign rsp_valid  = (state_reg == ST_RSP);
    assign rsp_data   = rsp_data_reg;
    assign rsp_sel    = idx_reg;
    assign busy       = (state_reg != ST_IDLE) || draining;

endmodule

// File: tb/tb_fxp8s_pe_seq.sv
// Randomised self-checking bench for fxp8s_pe_seq with a behavioural PE bus and a response scoreboard.
// Expects FXP8S_SEQ_CLR_EN to be set the same way as for the design.
module tb_fxp8s_pe_seq;
    import fxp8s_pkg::*;

    localparam int NPE   = 5;
    localparam int SEL_W = 3;
    localparam int DRAIN = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [SEL_W-1:0] cmd_sel = '0;
    logic             cmd_all = 1'b0;
    logic [7:0]       cmd_data = '0;
    logic             pe_in_row;
    logic [NPE-1:0]   pe_en_in;
    logic [7:0]       pe_in_data;
    logic [NPE-1:0]   pe_en_out;
    logic [7:0]       pe_out_data;
    logic             pe_rstn;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [7:0]       rsp_data;
    logic [SEL_W-1:0] rsp_sel;
    logic             busy;

    always #5 clk = ~clk;

    fxp8s_pe_seq #(.NPE(NPE), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_all(cmd_all), .cmd_data(cmd_data),
        .pe_in_row(pe_in_row), .pe_en_in(pe_en_in), .pe_in_data(pe_in_data),
        .pe_en_out(pe_en_out), .pe_out_data(pe_out_data), .pe_rstn(pe_rstn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_sel(rsp_sel), .busy(busy)
    );

    // Behavioural PEs: accumulators clear on pe_rstn, the enabled PE drives the bus, else junk.
    logic [7:0] acc_live [NPE];
    logic       set_req = 1'b0;
    int         set_idx = 0;
    logic [7:0] set_val = '0;
    logic [7:0] model_acc [NPE];

    always @(posedge clk) begin
        if (!pe_rstn) begin
            for (int i = 0; i < NPE; i++) acc_live[i] <= '0;
        end else if (set_req) begin
            acc_live[set_idx] <= set_val;
        end
    end

    always_comb begin
        pe_out_data = 8'hA5;
        for (int i = 0; i < NPE; i++)
            if (pe_en_out == (NPE'(1) << i)) pe_out_data = acc_live[i];
    end

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [7:0]       data;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_mode = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ~rsp_ready;
            2:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: bus sanity every cycle, response ordering and stall stability via the scoreboard.
    logic hold_v = 1'b0;
    rsp_t hold_r;
    rsp_t mon_e;
    always @(negedge clk) begin
        if (pe_en_out != '0) begin
            check("en_out_onehot", 32'($countones(pe_en_out)), 32'd1);
            check("en_out_vs_en_in", 32'(pe_en_in), 32'd0);
        end
        if (rst || !rsp_valid) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("rsp_stall_data", 32'(rsp_data), 32'(hold_r.data));
                check("rsp_stall_sel", 32'(rsp_sel), 32'(hold_r.sel));
            end
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    check("rsp_sel", 32'(rsp_sel), 32'(mon_e.sel));
                    $display("rsp sel=%0d data=0x%02h", rsp_sel, rsp_data);
                end
                hold_v = 1'b0;
            end else begin
                hold_v      = 1'b1;
                hold_r.data = rsp_data;
                hold_r.sel  = rsp_sel;
            end
        end
    end

    task automatic pe_load(input int i, input logic [7:0] v);
        @(negedge clk);
        set_req = 1'b1; set_idx = i; set_val = v; model_acc[i] = v;
        @(posedge clk); #1;
        set_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Present one command, wait for acceptance, then check the cycle after the accepting edge.
    task automatic issue(input logic [1:0] op, input int sel, input logic all,
                         input logic [7:0] data, output int waited);
        logic [NPE-1:0] en_exp;
        rsp_t           e;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = SEL_W'(sel); cmd_all = all; cmd_data = data;
        #1;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        $display("cmd op=%0d sel=%0d all=%0d data=0x%02h waited=%0d", op, sel, all, data, waited);
        en_exp = all ? '1 : ((sel < NPE) ? (NPE'(1) << sel) : '0);
        case (op)
            OP_ROW, OP_COL: begin
                check("wr_en_in", 32'(pe_en_in), 32'(en_exp));
                check("wr_in_row", 32'(pe_in_row), 32'(op == OP_ROW));
                check("wr_in_data", 32'(pe_in_data), 32'(data));
            end
            OP_READ: begin
                check("rd_en_out", 32'(pe_en_out), all ? 32'd1 : 32'(en_exp));
                if (all) begin
                    for (int i = 0; i < NPE; i++) begin
                        e.sel = SEL_W'(i); e.data = model_acc[i];
                        exp_q.push_back(e);
                    end
                end else begin
                    e.sel  = SEL_W'(sel);
                    e.data = (sel < NPE) ? model_acc[sel] : 8'h00;
                    exp_q.push_back(e);
                end
            end
            default: ;
        endcase
    endtask

    int w;
    int cyc;

    initial begin
        for (int i = 0; i < NPE; i++) model_acc[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pe_rstn", 32'(pe_rstn), 32'd0);
        check("rst_en_in", 32'(pe_en_in), 32'd0);
        check("rst_in_row", 32'(pe_in_row), 32'd0);
        check("rst_in_data", 32'(pe_in_data), 32'd0);
        check("rst_en_out", 32'(pe_en_out), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_sel", 32'(rsp_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_rstn_low", 32'(pe_rstn), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("post_rst_rstn_high", 32'(pe_rstn), 32'd1);

        for (int i = 0; i < NPE; i++) pe_load(i, 8'($urandom));
        pe_load(1, 8'h0A);

        // Three ROW writes then a COL to PE1, back to back, then the pulse must drop.
        for (int i = 0; i < 3; i++) issue(OP_ROW, 1, 1'b0, 8'h05, w);
        issue(OP_COL, 1, 1'b0, 8'h02, w);
        @(posedge clk); #1;
        check("wr_pulse_end", 32'(pe_en_in), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        wait_idle();
        issue(OP_READ, 1, 1'b0, 8'h00, w);
        @(posedge clk); #1;
        check("rd_latency_valid", 32'(rsp_valid), 32'd1);
        wait_idle();

        // READ right behind a COL is held off for the drain window.
        issue(OP_COL, 3, 1'b0, 8'h7F, w);
        issue(OP_READ, 3, 1'b0, 8'h00, w);
        check("rd_holdoff_cycles", 32'(w), 32'(DRAIN));
        wait_idle();

        // Read-all with stalling consumer, then at full rate for throughput.
        rdy_mode = 1;
        issue(OP_READ, 0, 1'b1, 8'h00, w);
        wait_idle();
        rdy_mode = 0;
        @(posedge clk);
        issue(OP_READ, 2, 1'b1, 8'h00, w);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("rd_all_cycles", 32'(cyc), 32'(2 * NPE));
        wait_idle();

        // Out-of-range selects.
        issue(OP_READ, 5, 1'b0, 8'h00, w);
        wait_idle();
        issue(OP_READ, 7, 1'b0, 8'h00, w);
        wait_idle();
        issue(OP_ROW, 6, 1'b0, 8'h33, w);
        issue(OP_COL, 1, 1'b1, 8'hC4, w);
        wait_idle();

        issue(OP_CLEAR, 0, 1'b0, 8'h00, w);
`ifdef FXP8S_SEQ_CLR_EN
        check("clr_rstn_low", 32'(pe_rstn), 32'd0);
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("clr_rstn_high", 32'(pe_rstn), 32'd1);
        check("clr_ready_back", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < NPE; i++) model_acc[i] = '0;
`else
        check("noclr_waited", 32'(w), 32'd0);
        check("noclr_rstn", 32'(pe_rstn), 32'd1);
        check("noclr_busy", 32'(busy), 32'd0);
`endif
        issue(OP_READ, 0, 1'b1, 8'h00, w);
        wait_idle();

        // Random command mix against the reference model.
        for (int k = 0; k < 150; k++) begin
            if (k % 10 == 0) begin
                rdy_mode = $urandom_range(0, 2);
                wait_idle();
                pe_load($urandom_range(0, NPE - 1), 8'($urandom));
            end
            issue(2'($urandom_range(0, 2)), $urandom_range(0, 7),
                  ($urandom_range(0, 3) == 0), 8'($urandom), w);
        end
        rdy_mode = 0;
        wait_idle();

        // Reset while a response is pending drops it and pulses pe_rstn.
        rdy_mode = 3;
        @(posedge clk);
        issue(OP_READ, 2, 1'b0, 8'h00, w);
        cyc = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_rsp_seen", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NPE; i++) model_acc[i] = '0;
        @(posedge clk); #1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_rstn", 32'(pe_rstn), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        issue(OP_READ, 0, 1'b1, 8'h00, w);
        wait_idle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
        $fatal(1, "watchdog");
    end

endmodule
